// File: rtl/note_player.sv
// note_player: turns a 7-bit note stream (0 = rest, 1..127 = MIDI note) into a
//   square-wave speaker output, with a programmable silence gap between notes.
// Latency: a new note is taken on the first edge it is seen. It starts in TONE
//   with speaker low, and the first rise comes H edges later. A changed note is
//   taken GAP_CYCLES edges after the change is seen.
// Backpressure: none. The note input is a level; a change made during a gap is
//   only sampled when the gap ends.
//
// Ports:
//   clk          - 50 MHz system clock (the pitch table assumes this rate)
//   reset        - asynchronous, active-low reset
//   note         - requested note, same clock domain, 0 = rest
//   speaker      - square-wave audio output
//   active       - high while a tone is sounding (state TONE)
//   note_latched - note currently sounding, 0 in IDLE and GAP
//   note_start   - one-cycle pulse on every entry to TONE
module note_player #(
  parameter int GAP_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] note,
  output logic       speaker,
  output logic       active,
  output logic [6:0] note_latched,
  output logic       note_start
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // The gap counter only has to hold GAP_CYCLES-1. It stays at least one bit
  // wide so that GAP_CYCLES = 0 still elaborates.
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam logic [GW-1:0] GAP_LOAD = NO_GAP ? '0 : GW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [21:0]   half_cnt;
  logic [GW-1:0] gap_cnt;

  logic [21:0]   load_m1;    // H-1 for the note on the input
  logic [21:0]   reload_m1;  // H-1 for the note already latched
  logic          note_diff;
  logic          take_note;

  // Half-period in clk cycles, minus one. The table holds octave-10
  // half-periods (25e6 / f, rounded). Lower octaves are exact doublings, so a
  // left shift by (10 - octave) gives them. The largest value, 2986 << 10,
  // still fits in 22 bits.
  function automatic logic [21:0] half_period_m1(input logic [6:0] n);
    logic [11:0] base;
    logic [3:0]  oct;
    logic [3:0]  pc;
    oct = 4'(n / 7'd12);
    pc  = 4'(n % 7'd12);
    case (pc)
      4'd0:    base = 12'd2986;
      4'd1:    base = 12'd2819;
      4'd2:    base = 12'd2660;
      4'd3:    base = 12'd2511;
      4'd4:    base = 12'd2370;
      4'd5:    base = 12'd2237;
      4'd6:    base = 12'd2112;
      4'd7:    base = 12'd1993;
      4'd8:    base = 12'd1881;
      4'd9:    base = 12'd1776;
      4'd10:   base = 12'd1676;
      default: base = 12'd1582;
    endcase
    return ({10'd0, base} << (4'd10 - oct)) - 22'd1;
  endfunction

  assign load_m1   = half_period_m1(note);
  assign reload_m1 = half_period_m1(note_latched);
  assign note_diff = (note != note_latched);

  // A new note is taken in three cases:
  //   - from IDLE;
  //   - at the end of a gap;
  //   - directly from TONE when there is no gap.
  // All three do the same thing, so the sequential block handles them once.
  always_comb begin
    take_note = 1'b0;
    if (note != 7'd0) begin
      case (state)
        ST_IDLE: take_note = 1'b1;
        ST_GAP:  take_note = (gap_cnt == '0);
        ST_TONE: take_note = NO_GAP && note_diff;
        default: take_note = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      speaker      <= 1'b0;
      active       <= 1'b0;
      note_latched <= 7'd0;
      note_start   <= 1'b0;
      half_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      note_start <= 1'b0;
      if (take_note) begin
        state        <= ST_TONE;
        active       <= 1'b1;
        note_latched <= note;
        half_cnt     <= load_m1;
        speaker      <= 1'b0;
        note_start   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            speaker <= 1'b0;
          end

          ST_TONE: begin
            // A note change takes priority over a half-period toggle that
            // falls in the same cycle. The toggle is dropped.
            if (note_diff) begin
              speaker      <= 1'b0;
              active       <= 1'b0;
              note_latched <= 7'd0;
              if (NO_GAP) begin
                // Only a change to rest reaches here; any other change was
                // relatched through take_note.
                state <= ST_IDLE;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else if (half_cnt == '0) begin
              speaker  <= ~speaker;
              half_cnt <= reload_m1;
            end else begin
              half_cnt <= half_cnt - 22'd1;
            end
          end

          ST_GAP: begin
            speaker <= 1'b0;
            // At gap end with note = 0 we fall to IDLE. A nonzero note at gap
            // end was already handled by take_note.
            if (gap_cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end

          default: begin
            state        <= ST_IDLE;
            speaker      <= 1'b0;
            active       <= 1'b0;
            note_latched <= 7'd0;
          end
        endcase
      end
    end
  end

endmodule
